// File: rtl/wb_slave_regbank.sv
// Pipelined Wishbone B4 slave register bank with read-only masking and a hardware update port.
// Optional macro WB_REGBANK_ERR_EN: out-of-range accesses answer with err_o instead of ack_o.
module wb_slave_regbank #(
  parameter int                      ADDR_WIDTH   = 16,
  parameter int                      DATA_WIDTH   = 32,
  parameter int                      GRANULE      = 8,
  parameter int                      REGISTER_NUM = 16,
  parameter logic [REGISTER_NUM-1:0] RO_MASK      = '0,
  localparam int                     SEL_WIDTH    = DATA_WIDTH / GRANULE
) (
  input  logic                             clk_i,
  input  logic                             rst_n_i,
  input  logic [ADDR_WIDTH-1:0]            adr_i,
  input  logic [DATA_WIDTH-1:0]            dat_i,
  output logic [DATA_WIDTH-1:0]            dat_o,
  input  logic [SEL_WIDTH-1:0]             sel_i,
  input  logic                             we_i,
  input  logic                             stb_i,
  input  logic                             cyc_i,
  output logic                             stall_o,
  output logic                             ack_o,
  output logic                             err_o,
  input  logic [REGISTER_NUM-1:0]          hw_we_i,
  input  logic [REGISTER_NUM*DATA_WIDTH-1:0] hw_dat_i,
  output logic [REGISTER_NUM*DATA_WIDTH-1:0] regs_o,
  output logic [REGISTER_NUM-1:0]          wr_pulse_o
);

  logic [DATA_WIDTH-1:0]   regs_q [REGISTER_NUM];
  logic [DATA_WIDTH-1:0]   regs_d [REGISTER_NUM];
  logic [DATA_WIDTH-1:0]   dat_q, dat_d;
  logic [REGISTER_NUM-1:0] wr_pulse_q, wr_pulse_d;
  logic                    ack_q, ack_d;

  logic [REGISTER_NUM-1:0] hit;
  logic [DATA_WIDTH-1:0]   selMask;
  logic [DATA_WIDTH-1:0]   readMux;
  logic                    inRange;
  logic                    accept;
  logic                    busWr;

  // One-hot address decode; an out-of-range address simply decodes to no register.
  always_comb begin
    hit = '0;
    for (int k = 0; k < REGISTER_NUM; k++) begin
      hit[k] = (adr_i == ADDR_WIDTH'(k));
    end
  end

  always_comb begin
    selMask = '0;
    for (int i = 0; i < SEL_WIDTH; i++) begin
      selMask[i*GRANULE +: GRANULE] = {GRANULE{sel_i[i]}};
    end
  end

  assign inRange = |hit;
  assign stall_o = cyc_i & stb_i & (|(hit & hw_we_i));
  assign accept  = cyc_i & stb_i & ~stall_o;
  assign busWr   = accept & we_i;

  always_comb begin
    readMux = '0;
    for (int k = 0; k < REGISTER_NUM; k++) begin
      if (hit[k]) readMux = regs_q[k];
    end
  end

  // Hardware update has priority; a colliding bus write is stalled so both never apply at once.
  always_comb begin
    for (int k = 0; k < REGISTER_NUM; k++) begin
      regs_d[k] = regs_q[k];
      if (hw_we_i[k]) begin
        regs_d[k] = hw_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
      end else if (busWr && hit[k] && !RO_MASK[k]) begin
        regs_d[k] = (regs_q[k] & ~selMask) | (dat_i & selMask);
      end
    end
  end

  always_comb begin
    dat_d      = '0;
    wr_pulse_d = '0;
    if (accept && !we_i) dat_d = readMux & selMask;
    if (busWr) wr_pulse_d = hit & ~RO_MASK;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < REGISTER_NUM; k++) begin
        regs_q[k] <= '0;
      end
      dat_q      <= '0;
      wr_pulse_q <= '0;
      ack_q      <= 1'b0;
    end else begin
      for (int k = 0; k < REGISTER_NUM; k++) begin
        regs_q[k] <= regs_d[k];
      end
      dat_q      <= dat_d;
      wr_pulse_q <= wr_pulse_d;
      ack_q      <= ack_d;
    end
  end

`ifdef WB_REGBANK_ERR_EN
  logic err_q, err_d;

  assign ack_d = accept & inRange;
  assign err_d = accept & ~inRange;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) err_q <= 1'b0;
    else          err_q <= err_d;
  end

  assign err_o = err_q & cyc_i;
`else
  // Out-of-range accesses are acked with zero data; the write is dropped by the decode.
  assign ack_d = accept;
  assign err_o = 1'b0;
`endif

  assign ack_o      = ack_q & cyc_i;
  assign dat_o      = dat_q;
  assign wr_pulse_o = wr_pulse_q;

  always_comb begin
    regs_o = '0;
    for (int k = 0; k < REGISTER_NUM; k++) begin
      regs_o[k*DATA_WIDTH +: DATA_WIDTH] = regs_q[k];
    end
  end

endmodule

// File: tb/tb_wb_slave_regbank.sv
// Directed self-checking bench for wb_slave_regbank (16 x 32-bit registers, register 5 read-only).
module tb_wb_slave_regbank;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int RN = 16;
  localparam int SW = DW / 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [AW-1:0]     adr = '0;
  logic [DW-1:0]     datIn = '0;
  logic [DW-1:0]     datOut;
  logic [SW-1:0]     sel = '0;
  logic              we = 1'b0;
  logic              stb = 1'b0;
  logic              cyc = 1'b0;
  logic              stall;
  logic              ack;
  logic              err;
  logic [RN-1:0]     hwWe = '0;
  logic [RN*DW-1:0]  hwDat = '0;
  logic [RN*DW-1:0]  regsOut;
  logic [RN-1:0]     wrPulse;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] expRegs [RN];

  logic          rAck, rErr;
  logic [DW-1:0] rDat;
  logic [RN-1:0] rPulse;

  wb_slave_regbank #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .GRANULE     (8),
    .REGISTER_NUM(RN),
    .RO_MASK     (16'h0020)
  ) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .adr_i     (adr),
    .dat_i     (datIn),
    .dat_o     (datOut),
    .sel_i     (sel),
    .we_i      (we),
    .stb_i     (stb),
    .cyc_i     (cyc),
    .stall_o   (stall),
    .ack_o     (ack),
    .err_o     (err),
    .hw_we_i   (hwWe),
    .hw_dat_i  (hwDat),
    .regs_o    (regsOut),
    .wr_pulse_o(wrPulse)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [RN*DW-1:0] expFlat();
    logic [RN*DW-1:0] f;
    f = '0;
    for (int k = 0; k < RN; k++) f[k*DW +: DW] = expRegs[k];
    return f;
  endfunction

  task automatic checkOutput(input string tag, input logic [RN*DW-1:0] obs, input logic [RN*DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one request, waits out any stall, and samples the response cycle.
  task automatic applyStimulus(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                               input logic [SW-1:0] s, output logic oAck, output logic oErr,
                               output logic [DW-1:0] oDat, output logic [RN-1:0] oPulse);
    bit accepted;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; datIn = d; sel = s;
    accepted = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (!stall) begin
        accepted = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!accepted) checkOutput("stallTimeout", 0, 1);
    @(posedge clk); #1;
    stb = 1'b0; we = 1'b0;
    @(negedge clk);
    oAck = ack; oErr = err; oDat = datOut; oPulse = wrPulse;
    @(posedge clk); #1;
    cyc = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < RN; k++) expRegs[k] = '0;

    #12;
    checkOutput("resetAck", ack, 0);
    checkOutput("resetErr", err, 0);
    checkOutput("resetDat", datOut, 0);
    checkOutput("resetPulse", wrPulse, 0);
    checkOutput("resetRegs", regsOut, expFlat());
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(1'b1, 16'd3, 32'hDEADBEEF, 4'hF, rAck, rErr, rDat, rPulse);
    expRegs[3] = 32'hDEADBEEF;
    checkOutput("wr3Ack", rAck, 1);
    checkOutput("wr3Pulse", rPulse, 16'h0008);
    checkOutput("wr3Regs", regsOut, expFlat());
    checkOutput("wr3PulseGone", wrPulse, 0);
    applyStimulus(1'b0, 16'd3, 32'h0, 4'hF, rAck, rErr, rDat, rPulse);
    checkOutput("rd3Ack", rAck, 1);
    checkOutput("rd3Dat", rDat, 32'hDEADBEEF);

    applyStimulus(1'b1, 16'd4, 32'hAAAAAAAA, 4'hF, rAck, rErr, rDat, rPulse);
    applyStimulus(1'b1, 16'd4, 32'h11223344, 4'b0101, rAck, rErr, rDat, rPulse);
    expRegs[4] = 32'hAA22AA44;
    checkOutput("partialRegs", regsOut, expFlat());
    applyStimulus(1'b0, 16'd4, 32'h0, 4'b0011, rAck, rErr, rDat, rPulse);
    checkOutput("partialRdDat", rDat, 32'h0000AA44);

    applyStimulus(1'b1, 16'd5, 32'h00001234, 4'hF, rAck, rErr, rDat, rPulse);
    checkOutput("roAck", rAck, 1);
    checkOutput("roPulse", rPulse, 0);
    checkOutput("roRegs", regsOut, expFlat());
    @(posedge clk); #1;
    hwWe[5] = 1'b1; hwDat[5*DW +: DW] = 32'h00000055;
    @(posedge clk); #1;
    hwWe = '0;
    expRegs[5] = 32'h00000055;
    @(negedge clk);
    checkOutput("roHwRegs", regsOut, expFlat());

    // Bus write colliding with a two-cycle hardware update of the same register.
    @(posedge clk); #1;
    hwWe[2] = 1'b1; hwDat[2*DW +: DW] = 32'h0BAD0BAD;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 16'd2; datIn = 32'hCAFEF00D; sel = 4'hF;
    @(negedge clk);
    checkOutput("stallCyc1", stall, 1);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("stallCyc2", stall, 1);
    checkOutput("stallHwVal", regsOut[2*DW +: DW], 32'h0BAD0BAD);
    @(posedge clk); #1;
    hwWe = '0;
    @(negedge clk);
    checkOutput("stallReleased", stall, 0);
    @(posedge clk); #1;
    stb = 1'b0; we = 1'b0;
    @(negedge clk);
    expRegs[2] = 32'hCAFEF00D;
    checkOutput("stallAck", ack, 1);
    checkOutput("stallPulse", wrPulse, 16'h0004);
    checkOutput("stallRegs", regsOut, expFlat());
    @(posedge clk); #1;
    cyc = 1'b0;

    applyStimulus(1'b1, 16'd0, 32'h01010101, 4'hF, rAck, rErr, rDat, rPulse);
    applyStimulus(1'b1, 16'd1, 32'h10203040, 4'hF, rAck, rErr, rDat, rPulse);
    expRegs[0] = 32'h01010101;
    expRegs[1] = 32'h10203040;

    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 16'd0;
    for (int k = 1; k < 4; k++) begin
      @(posedge clk); #1;
      adr = AW'(k);
      @(negedge clk);
      checkOutput($sformatf("b2bAck%0d", k - 1), ack, 1);
      checkOutput($sformatf("b2bDat%0d", k - 1), datOut, expRegs[k-1]);
    end
    @(posedge clk); #1;
    stb = 1'b0; cyc = 1'b0;
    @(negedge clk);
    checkOutput("b2bAckDropped", ack, 0);

    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 16'd6; datIn = 32'h00000066; sel = 4'hF;
    @(posedge clk); #1;
    we = 1'b0;
    @(negedge clk);
    expRegs[6] = 32'h00000066;
    checkOutput("rawWrPulse", wrPulse, 16'h0040);
    @(posedge clk); #1;
    stb = 1'b0;
    @(negedge clk);
    checkOutput("rawRdAck", ack, 1);
    checkOutput("rawRdDat", datOut, 32'h00000066);
    @(posedge clk); #1;
    cyc = 1'b0;

    applyStimulus(1'b1, 16'd7, 32'hFFFFFFFF, 4'h0, rAck, rErr, rDat, rPulse);
    checkOutput("sel0Pulse", rPulse, 16'h0080);
    checkOutput("sel0Regs", regsOut, expFlat());

    applyStimulus(1'b1, 16'h0020, 32'hFFFFFFFF, 4'hF, rAck, rErr, rDat, rPulse);
`ifdef WB_REGBANK_ERR_EN
    checkOutput("oorWrAck", rAck, 0);
    checkOutput("oorWrErr", rErr, 1);
`else
    checkOutput("oorWrAck", rAck, 1);
    checkOutput("oorWrErr", rErr, 0);
`endif
    checkOutput("oorWrPulse", rPulse, 0);
    checkOutput("oorWrRegs", regsOut, expFlat());
    applyStimulus(1'b0, 16'h0020, 32'h0, 4'hF, rAck, rErr, rDat, rPulse);
    checkOutput("oorRdDat", rDat, 0);

    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 16'd8; datIn = 32'h00000088; sel = 4'hF;
    @(posedge clk); #1;
    we = 1'b0;
    @(negedge clk);
    checkOutput("preResetPulse", wrPulse, 16'h0100);
    #1;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < RN; k++) expRegs[k] = '0;
    checkOutput("midResetAck", ack, 0);
    checkOutput("midResetErr", err, 0);
    checkOutput("midResetDat", datOut, 0);
    checkOutput("midResetPulse", wrPulse, 0);
    checkOutput("midResetRegs", regsOut, expFlat());
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(1'b0, 16'd3, 32'h0, 4'hF, rAck, rErr, rDat, rPulse);
    checkOutput("postResetRdAck", rAck, 1);
    checkOutput("postResetRdDat", rDat, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
